readout_sequencer: RTL and testbench
====================================

# readout_sequencer

Clock-domain consumer of the instruction pulses `inst_rst`, `inst_start` and `inst_readout`, which are produced on every instruction-register write. It synchronizes each pulse into `clk` and runs the acquisition/readout state machine:
- circular write-pointer generation while sampling;
- stop-address capture on trigger;
- ordered channel-by-channel readout of the sample memory through a valid/ready output stream.

## Interface
- `NUM_CH`, default 8: number of channels read out per readout command.
- `SAMPLES`, default 256: samples per channel; power of two, ≥ 4.
- `DATA_W`, default 12: sample word width.
- `SYNC_STAGES`, default 2: flops in each input synchronizer.

Ports:
- `clk` in 1: block clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `inst_rst` in 1: soft-reset pulse; asynchronous to `clk`, high for the CSB-low width.
- `inst_start` in 1: start-acquisition pulse; asynchronous to `clk`.
- `inst_readout` in 1: start-readout pulse; asynchronous to `clk`.
- `trigger` in 1: stop trigger; synchronous to `clk`, level.
- `sample_en` out 1: high while acquiring.
- `wr_addr` out log2(SAMPLES): circular write pointer.
- `stop_addr` out log2(SAMPLES): address written on the trigger cycle.
- `ram_re` out 1: memory read strobe.
- `ram_ch` out log2(NUM_CH) (min 1): read channel.
- `ram_addr` out log2(SAMPLES): read address.
- `ram_rdata` in DATA_W: read data, valid exactly 1 cycle after `ram_re`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer ready.
- `out_data` out DATA_W: sample word.
- `out_last` out 1: high with the final word of a readout.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Each instruction input passes through a `SYNC_STAGES` synchronizer followed by a rising-edge detector, giving one `clk`-cycle pulse per write: `rst_p`, `start_p`, `rdo_p`.
- Source pulses shorter than `SYNC_STAGES`+1 clk periods are unsupported.
- Priority within a cycle: `rst_p` > `rdo_p` > `start_p` > `trigger`.
- `rst_p` in any state:
  - go to IDLE;
  - clear `wr_addr`, `stop_addr`, channel/sample counters and `out_data`;
  - drop `out_valid` without completing the transfer.
- **IDLE**: `start_p` → ACQUIRE with `wr_addr`=0. `rdo_p` and `trigger` are ignored.
- **ACQUIRE**:
  - `sample_en`=1.
  - `wr_addr` increments by 1 every cycle and wraps from SAMPLES-1 to 0.
  - `trigger`=1 → latch `stop_addr`=`wr_addr` (the current-cycle value), go to HOLD; `wr_addr` freezes.
  - `start_p` is ignored.
  - `rdo_p` → HOLD with `stop_addr`=current `wr_addr` (forced stop).
- **HOLD**:
  - `sample_en`=0.
  - `rdo_p` → FETCH with ch=0, idx=0.
  - `start_p` → ACQUIRE with `wr_addr`=0 (re-arm).
- **FETCH** (1 cycle): `ram_re`=1, `ram_ch`=ch, `ram_addr`=(`stop_addr`+1+idx) mod SAMPLES → LATCH. Oldest sample first; the stop sample is last.
- **LATCH** (1 cycle): `out_data`←`ram_rdata` → PRESENT.
- **PRESENT**:
  - `out_valid`=1.
  - `out_last`=1 iff ch=NUM_CH-1 and idx=SAMPLES-1.
  - On `out_valid`&&`out_ready`:
    - if last → IDLE;
    - else if idx=SAMPLES-1 → idx=0, ch+1, FETCH;
    - else idx+1, FETCH.
- `rdo_p` and `start_p` during FETCH/LATCH/PRESENT are ignored; only `rst_p` aborts a readout.
- Address arithmetic is log2(SAMPLES) bits with natural wrap; `stop_addr`=SAMPLES-1 starts readout at address 0.

## Timing
- Reset values (`rstn`=0): every output 0; state IDLE; synchronizer flops 0.
- An input pulse whose rise is first sampled high at clk edge k yields an internal pulse after edge k+`SYNC_STAGES`. The state change is visible after edge k+`SYNC_STAGES`+1.
- With defaults, `sample_en` rises 3 cycles after the first edge sampling `inst_start` high.
- `stop_addr` is valid the cycle after `trigger` and holds until the next `rst_p`/ACQUIRE entry.
- Per word: minimum 3 cycles (FETCH, LATCH, PRESENT with `out_ready` held high). Full readout minimum is 3·NUM_CH·SAMPLES cycles.
- Output stream:
  - `out_data`/`out_last` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake, except on `rst_p` or `rstn`.
- `busy` is registered from the state: it rises the cycle the FSM leaves IDLE and falls the cycle after the last handshake.

## Structure
- Shared package `readout_pkg`:
  - state enum (IDLE, ACQUIRE, HOLD, FETCH, LATCH, PRESENT);
  - instruction code constants (RST=1, READOUT=2, START=3), shared with the instruction decoder.
- Sub-module `pulse_sync`: parameterized `SYNC_STAGES` synchronizer plus rising-edge detector, instantiated three times.
- The FSM, counters and output register live in `readout_sequencer`.

## Test plan
- SAMPLES=16, NUM_CH=2:
  - `inst_start` 3 clk wide → `sample_en` high 3 cycles later, `wr_addr` counts 0..15, 0, …
  - `trigger` at `wr_addr`=5 → `stop_addr`=5, HOLD.
- Same setup, then `inst_readout` with `out_ready`=1 → 32 words:
  - ch0 addresses 6..15, 0..5, then ch1 in the same order;
  - `out_last` only on word 32;
  - `busy` low after.
- Random `out_ready` backpressure → `out_data` stable while stalled; no word dropped or duplicated against a memory model.
- `inst_rst` during PRESENT of word 10 → IDLE, `out_valid`=0, `stop_addr`=0, and no further `ram_re`.
- `inst_readout` in IDLE, and `inst_start` during readout → no state change.
- `stop_addr`=15 → readout starts at address 0.
- `inst_readout` during ACQUIRE → `stop_addr` equals `wr_addr` at the synced pulse.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared definitions for the readout sequencer and the instruction decoder.
package readout_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_HOLD    = 3'd2,
        ST_FETCH   = 3'd3,
        ST_LATCH   = 3'd4,
        ST_PRESENT = 3'd5
    } state_t;

    // Instruction codes written into the instruction register.
    localparam logic [1:0] INST_RST     = 2'd1;
    localparam logic [1:0] INST_READOUT = 2'd2;
    localparam logic [1:0] INST_START   = 2'd3;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Brings an asynchronous instruction pulse into clk and emits a single
// registered one-cycle pulse on its rising edge.
module pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    // Synchronizer chain, delayed copy of its output, and registered edge pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            level_q <= sync_q[SYNC_STAGES-1];
            pulse   <= sync_q[SYNC_STAGES-1] & ~level_q;
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Acquisition / readout sequencer: circular write pointer while sampling,
// stop-address capture, then channel-by-channel readout of the sample memory
// oldest-sample-first over a valid/ready stream.
//
// Output stream handshake: a word transfers on a clock edge where out_valid
// and out_ready are both high. Once out_valid rises, out_data and out_last
// hold steady until that transfer; only a soft reset (inst_rst) or rstn can
// withdraw out_valid early.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SAMPLES     = 256,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          inst_rst,
    input  logic                          inst_start,
    input  logic                          inst_readout,
    input  logic                          trigger,
    output logic                          sample_en,
    output logic [$clog2(SAMPLES)-1:0]    wr_addr,
    output logic [$clog2(SAMPLES)-1:0]    stop_addr,
    output logic                          ram_re,
    output logic [ch_width(NUM_CH)-1:0]   ram_ch,
    output logic [$clog2(SAMPLES)-1:0]    ram_addr,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy,
    output state_t                        fsm_state
);

    localparam int AW = $clog2(SAMPLES);
    localparam int CW = ch_width(NUM_CH);
    localparam logic [AW-1:0] IDX_LAST = AW'(SAMPLES - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

    logic rst_p;
    logic start_p;
    logic rdo_p;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     stop_q, stop_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q;
    logic              is_last;

    pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (inst_rst),
        .pulse    (rst_p)
    );

    pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (inst_start),
        .pulse    (start_p)
    );

    pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rdo (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (inst_readout),
        .pulse    (rdo_p)
    );

    assign is_last = (ch_q == CH_LAST) && (idx_q == IDX_LAST);

    // State, counters and output word register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            stop_q  <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            stop_q  <= stop_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state and counter updates; soft reset overrides everything, then
    // readout, then start, then trigger.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        stop_d  = stop_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        data_d  = data_q;

        if (rst_p) begin
            state_d = ST_IDLE;
            wr_d    = '0;
            stop_d  = '0;
            idx_d   = '0;
            ch_d    = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        state_d = ST_ACQUIRE;
                        wr_d    = '0;
                        stop_d  = '0;
                    end
                end
                ST_ACQUIRE: begin
                    // A readout command acts as a forced stop at the current pointer.
                    if (rdo_p || trigger) begin
                        state_d = ST_HOLD;
                        stop_d  = wr_q;
                    end else begin
                        wr_d = wr_q + AW'(1);
                    end
                end
                ST_HOLD: begin
                    if (rdo_p) begin
                        state_d = ST_FETCH;
                        idx_d   = '0;
                        ch_d    = '0;
                    end else if (start_p) begin
                        state_d = ST_ACQUIRE;
                        wr_d    = '0;
                        stop_d  = '0;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    // Memory returns data one cycle after the read strobe.
                    data_d  = ram_rdata;
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            state_d = ST_IDLE;
                        end else if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            ch_d    = ch_q + CW'(1);
                            state_d = ST_FETCH;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state; read address starts just
    // past the stop sample so the oldest sample comes out first.
    assign sample_en = (state_q == ST_ACQUIRE);
    assign ram_re    = (state_q == ST_FETCH);
    assign ram_ch    = ram_re ? ch_q : '0;
    assign ram_addr  = ram_re ? (stop_q + AW'(1) + idx_q) : '0;
    assign out_valid = (state_q == ST_PRESENT);
    assign out_last  = out_valid && is_last;
    assign out_data  = data_q;
    assign wr_addr   = wr_q;
    assign stop_addr = stop_q;
    assign busy      = busy_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer with SAMPLES=16, NUM_CH=2.
module tb_readout_sequencer;
    import readout_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int SAMPLES = 16;
    localparam int DATA_W  = 12;
    localparam int AW      = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              inst_rst = 1'b0;
    logic              inst_start = 1'b0;
    logic              inst_readout = 1'b0;
    logic              trigger = 1'b0;
    logic              sample_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     stop_addr;
    logic              ram_re;
    logic [0:0]        ram_ch;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    state_t            fsm_state;

    readout_sequencer #(
        .NUM_CH(NUM_CH), .SAMPLES(SAMPLES), .DATA_W(DATA_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rstn(rstn), .inst_rst(inst_rst), .inst_start(inst_start),
        .inst_readout(inst_readout), .trigger(trigger), .sample_en(sample_en),
        .wr_addr(wr_addr), .stop_addr(stop_addr), .ram_re(ram_re), .ram_ch(ram_ch),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [DATA_W-1:0] mem [NUM_CH][SAMPLES];

    // Data only meaningful one cycle after a strobe; junk otherwise.
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_ch][ram_addr];
        else        ram_rdata <= DATA_W'($urandom);
    end

    task automatic fill_mem();
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < SAMPLES; a++)
                mem[c][a] = DATA_W'($urandom);
    endtask

    // ---------------- ready driver ----------------
    int rdy_mode = 0; // 0 low, 1 high, 2 random
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1)      out_ready = 1'b1;
        else if (rdy_mode == 2) out_ready = ($urandom_range(0, 2) != 0);
        else                    out_ready = 1'b0;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DATA_W:0] exp_q[$];   // {last, data}
    int              addr_q[$];  // ch*SAMPLES + addr
    int              hs_cnt = 0;
    bit              abort = 1'b0;
    bit              rdo_active = 1'b0;
    bit              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    // Readout order: each channel in turn, oldest sample (stop+1) to stop sample.
    task automatic build_exp(input int stop);
        exp_q.delete();
        addr_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < SAMPLES; i++) begin
                int a;
                a = (stop + 1 + i) % SAMPLES;
                exp_q.push_back({(c == NUM_CH - 1 && i == SAMPLES - 1), mem[c][a]});
                addr_q.push_back(c * SAMPLES + a);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ram_re) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ram_re_unexpected: got ch=%0d addr=%0d required no read", ram_ch, ram_addr);
                end else begin
                    int ea;
                    ea = addr_q.pop_front();
                    if (int'(ram_ch) * SAMPLES + int'(ram_addr) != ea) begin
                        errors++;
                        $display("FAIL ram_read_addr: got ch=%0d addr=%0d required ch=%0d addr=%0d",
                                 ram_ch, ram_addr, ea / SAMPLES, ea % SAMPLES);
                    end
                end
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got data=%0d required no word", out_data);
                end else begin
                    logic [DATA_W:0] e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[DATA_W-1:0]);
                    check("out_last", out_last, e[DATA_W]);
                end
            end
            if (prev_stall && !abort) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (rdo_active) check("sample_en_in_readout", sample_en, 0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inst(input logic [1:0] code, input logic v);
        case (code)
            INST_RST:     inst_rst = v;
            INST_READOUT: inst_readout = v;
            INST_START:   inst_start = v;
            default: ;
        endcase
    endtask

    // Called just after a rising edge; holds the pulse for three edges.
    task automatic pulse(input logic [1:0] code);
        set_inst(code, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        set_inst(code, 1'b0);
    endtask

    // Start acquisition, then stop it by trigger (mode 0) or by a readout
    // command (mode 1) raised when wr_addr has advanced `when` times.
    task automatic run_acq(input int mode, input int when, input int exp_stop);
        @(posedge clk); #1;
        pulse(INST_START);
        @(negedge clk);
        check("sample_en_before", sample_en, 0);
        for (int n = 0; n <= when; n++) begin
            @(posedge clk); #1;
            if (n == when) begin
                if (mode == 0) trigger = 1'b1;
                else           inst_readout = 1'b1;
            end
            @(negedge clk);
            check("sample_en_acq", sample_en, 1);
            check("wr_addr_count", wr_addr, n % SAMPLES);
        end
        if (mode == 0) begin
            @(posedge clk); #1;
            trigger = 1'b0;
        end else begin
            repeat (3) @(posedge clk);
            #1;
            inst_readout = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stop_addr", stop_addr, exp_stop);
        check("sample_en_hold", sample_en, 0);
        check("busy_hold", busy, 1);
        repeat (3) @(negedge clk);
        check("wr_addr_frozen", wr_addr, exp_stop);
        check("stop_addr_held", stop_addr, exp_stop);
    endtask

    task automatic do_readout(input int stop, input int rmode, input bit start_mid, input bit chk_len);
        int n;
        bit done;
        build_exp(stop);
        hs_cnt = 0;
        rdy_mode = rmode;
        rdo_active = 1'b1;
        @(posedge clk); #1;
        pulse(INST_READOUT);
        n = 0;
        done = 1'b0;
        fork
            begin
                while (!done && n < 3000) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (!busy) done = 1'b1;
                end
            end
            begin
                if (start_mid) begin
                    repeat (20) @(posedge clk);
                    #1;
                    pulse(INST_START);
                end
            end
        join
        rdo_active = 1'b0;
        rdy_mode = 0;
        check("readout_done", done, 1);
        if (chk_len) check("readout_cycles", n, 3 * NUM_CH * SAMPLES + 1);
        check("words_left", exp_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
        check("words_seen", hs_cnt, NUM_CH * SAMPLES);
        check("valid_after", out_valid, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int mode;      // 0 trigger, 1 forced stop by readout command
        int when;      // pointer steps before the stop request
        int exp_stop;
        int rmode;     // ready behaviour during readout
        bit start_mid; // start command in the middle of readout
        bit chk_len;   // check minimum readout duration
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{mode: 0, when: 5,  exp_stop: 5,  rmode: 1, start_mid: 1'b0, chk_len: 1'b1};
        vecs[1] = '{mode: 0, when: 31, exp_stop: 15, rmode: 2, start_mid: 1'b0, chk_len: 1'b0};
        vecs[2] = '{mode: 1, when: 9,  exp_stop: 12, rmode: 2, start_mid: 1'b0, chk_len: 1'b0};
        vecs[3] = '{mode: 0, when: 16, exp_stop: 0,  rmode: 1, start_mid: 1'b1, chk_len: 1'b1};
        vecs[4] = '{mode: 1, when: 14, exp_stop: 1,  rmode: 2, start_mid: 1'b0, chk_len: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sample_en", sample_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_stop_addr", stop_addr, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_ram_ch", ram_ch, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, ST_IDLE);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Readout command and trigger in IDLE are ignored.
        @(posedge clk); #1;
        trigger = 1'b1;
        pulse(INST_READOUT);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_sample_en", sample_en, 0);
            check("idle_ram_re", ram_re, 0);
        end
        @(posedge clk); #1;
        trigger = 1'b0;

        // Table-driven acquisitions and readouts.
        foreach (vecs[i]) begin
            fill_mem();
            run_acq(vecs[i].mode, vecs[i].when, vecs[i].exp_stop);
            do_readout(vecs[i].exp_stop, vecs[i].rmode, vecs[i].start_mid, vecs[i].chk_len);
        end

        // Soft reset while word 10 is presented.
        begin
            int guard;
            fill_mem();
            run_acq(0, 5, 5);
            build_exp(5);
            hs_cnt = 0;
            rdy_mode = 1;
            @(posedge clk); #1;
            pulse(INST_READOUT);
            guard = 0;
            while (hs_cnt < 9 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            rdy_mode = 0;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!(out_valid && !out_ready) && guard < 20);
            check("rst_word_presented", out_valid, 1);
            check("rst_words_before", hs_cnt, 9);
            check("rst_word10_data", out_data, exp_q[0][DATA_W-1:0]);
            @(posedge clk); #1;
            abort = 1'b1;
            pulse(INST_RST);
            @(posedge clk); #1;
            @(negedge clk);
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_stop_addr", stop_addr, 0);
            check("abort_wr_addr", wr_addr, 0);
            check("abort_out_data", out_data, 0);
            check("abort_state", fsm_state, ST_IDLE);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("abort_no_ram_re", ram_re, 0);
            end
            check("abort_words", hs_cnt, 9);
            exp_q.delete();
            addr_q.delete();
            abort = 1'b0;
        end

        // After the abort a normal acquisition/readout still works.
        fill_mem();
        run_acq(0, 20, 4);
        do_readout(4, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
